// File: rtl/axi_lite_dram_model.sv
// Word-addressed AXI4-Lite-style memory slave standing in for off-chip DRAM; read and write channels are independent.
// Latency: R_VALID rises RD_LAT cycles after the AR handshake; B_VALID rises WR_LAT cycles after the W handshake.
// Backpressure: one transaction in flight per channel; R/B are held until accepted, while AR/AW/W stay stalled.
module axi_lite_dram_model #(
  parameter int    DATA_W    = 64,
  parameter int    ADDR_W    = 32,
  parameter int    DEPTH     = 8192,
  parameter int    RD_LAT    = 4,
  parameter int    WR_LAT    = 2,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              AR_VALID,
  input  logic [ADDR_W-1:0] AR_ADDR,
  output logic              AR_READY,
  output logic              R_VALID,
  output logic [DATA_W-1:0] R_DATA,
  output logic [1:0]        R_RESP,
  input  logic              R_READY,
  input  logic              AW_VALID,
  input  logic [ADDR_W-1:0] AW_ADDR,
  output logic              AW_READY,
  input  logic              W_VALID,
  input  logic [DATA_W-1:0] W_DATA,
  output logic              W_READY,
  output logic              B_VALID,
  output logic [1:0]        B_RESP,
  input  logic              B_READY
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      RD_CNT0 = 8'(RD_LAT - 1);
  localparam logic [7:0]      WR_CNT0 = 8'(WR_LAT - 1);
  localparam logic [1:0]      OKAY    = 2'b00;
  localparam logic [1:0]      SLVERR  = 2'b10;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_WAIT, WR_RESP} wr_state_t;

  // Storage is deliberately outside the reset domain: contents survive rst_n.
  logic [DATA_W-1:0] mem [DEPTH];

  rd_state_t         rd_state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [7:0]        rd_cnt_q;
  logic              ar_ready_q;
  logic              r_valid_q;
  logic [DATA_W-1:0] r_data_q;
  logic [1:0]        r_resp_q;

  wr_state_t         wr_state_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_cnt_q;
  logic              aw_ready_q;
  logic              w_ready_q;
  logic              b_valid_q;
  logic [1:0]        b_resp_q;

  logic              rd_ok;
  logic              wr_ok;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;

  // The range check is done on the full latched address; the index is only used once it passes.
  assign rd_ok  = ({1'b0, rd_addr_q} < DEPTH_X);
  assign wr_ok  = ({1'b0, wr_addr_q} < DEPTH_X);
  assign rd_idx = rd_addr_q[IDX_W-1:0];
  assign wr_idx = wr_addr_q[IDX_W-1:0];

  // Read channel FSM: accept address, count down the latency, then present data until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      rd_addr_q  <= '0;
      rd_cnt_q   <= '0;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= OKAY;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (AR_VALID) begin
            rd_addr_q  <= AR_ADDR;
            rd_cnt_q   <= RD_CNT0;
            ar_ready_q <= 1'b0;
            rd_state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rd_cnt_q == 8'd0) begin
            // Sampling here with a non-blocking read means a same-edge write commit is not seen.
            r_data_q   <= rd_ok ? mem[rd_idx] : '0;
            r_resp_q   <= rd_ok ? OKAY : SLVERR;
            r_valid_q  <= 1'b1;
            rd_state_q <= RD_DATA;
          end else begin
            rd_cnt_q <= rd_cnt_q - 8'd1;
          end
        end
        RD_DATA: begin
          if (R_READY) begin
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b1;
            rd_state_q <= RD_IDLE;
          end
        end
        default: begin
          rd_state_q <= RD_IDLE;
          ar_ready_q <= 1'b1;
          r_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write channel FSM: address first, then data, then a delayed response held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      wr_addr_q  <= '0;
      wr_cnt_q   <= '0;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= OKAY;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          if (AW_VALID) begin
            wr_addr_q  <= AW_ADDR;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            wr_state_q <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (W_VALID) begin
            w_ready_q  <= 1'b0;
            wr_cnt_q   <= WR_CNT0;
            wr_state_q <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (wr_cnt_q == 8'd0) begin
            b_valid_q  <= 1'b1;
            b_resp_q   <= wr_ok ? OKAY : SLVERR;
            wr_state_q <= WR_RESP;
          end else begin
            wr_cnt_q <= wr_cnt_q - 8'd1;
          end
        end
        WR_RESP: begin
          if (B_READY) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            wr_state_q <= WR_IDLE;
          end
        end
        default: begin
          wr_state_q <= WR_IDLE;
        end
      endcase
    end
  end

  // Commit on the W handshake edge; reset forces WR_IDLE so an unfinished write never lands.
  always_ff @(posedge clk) begin
    if (wr_state_q == WR_DATA && W_VALID && wr_ok) begin
      mem[wr_idx] <= W_DATA;
    end
  end

  assign AR_READY = ar_ready_q;
  assign R_VALID  = r_valid_q;
  assign R_DATA   = r_data_q;
  assign R_RESP   = r_resp_q;
  assign AW_READY = aw_ready_q;
  assign W_READY  = w_ready_q;
  assign B_VALID  = b_valid_q;
  assign B_RESP   = b_resp_q;

endmodule

// File: tb/tb_axi_lite_dram_model.sv
// Randomised bench for axi_lite_dram_model against an associative-array memory model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Responses are checked for latency, hold-while-stalled, range errors, same-edge ordering and reset.
module tb_axi_lite_dram_model;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int DEPTH = 8192;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          AR_VALID, AR_READY, R_VALID, R_READY;
  logic [AW-1:0] AR_ADDR;
  logic [DW-1:0] R_DATA;
  logic [1:0]    R_RESP;
  logic          AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
  logic [AW-1:0] AW_ADDR;
  logic [DW-1:0] W_DATA;
  logic [1:0]    B_RESP;

  always #5 clk = ~clk;

  axi_lite_dram_model #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
  );

  int total = 0;
  int bad = 0;

  // Reference memory: only words the bench has written are ever read back for data.
  logic [63:0] ref_mem [int];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_rdata(input logic [31:0] a);
    if (a >= DEPTH) return 64'h0;
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return 64'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return (a >= DEPTH) ? 2'b10 : 2'b00;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ar_ready"}, AR_READY, 1);
    check({tag, "_aw_ready"}, AW_READY, 1);
    check({tag, "_r_valid"}, R_VALID, 0);
    check({tag, "_w_ready"}, W_READY, 0);
    check({tag, "_b_valid"}, B_VALID, 0);
    check({tag, "_r_data"}, R_DATA, 0);
    check({tag, "_r_resp"}, R_RESP, 0);
    check({tag, "_b_resp"}, B_RESP, 0);
  endtask

  // Full read transaction; called on a falling edge, returns on a falling edge.
  task automatic do_read(input logic [31:0] a, input int hold);
    logic [63:0] exp_d;
    logic [1:0]  exp_r;
    int n;
    exp_d = exp_rdata(a);
    exp_r = exp_resp(a);
    AR_VALID = 1'b1;
    AR_ADDR  = a;
    n = 0;
    while (!AR_READY && n < 50) begin @(negedge clk); n++; end
    check("rd_ar_ready", AR_READY, 1);
    @(negedge clk);
    AR_VALID = 1'b0;
    AR_ADDR  = $urandom;
    check("rd_ar_drop", AR_READY, 0);
    n = 0;
    while (!R_VALID && n < 300) begin @(negedge clk); n++; end
    check("rd_latency", n, RD_LAT);
    for (int i = 0; i < hold; i++) begin
      check("rd_hold_valid", R_VALID, 1);
      check("rd_hold_data", R_DATA, exp_d);
      @(negedge clk);
    end
    check("rd_data", R_DATA, exp_d);
    check("rd_resp", R_RESP, exp_r);
    R_READY = 1'b1;
    @(negedge clk);
    R_READY = 1'b0;
    check("rd_valid_clear", R_VALID, 0);
    check("rd_ar_back", AR_READY, 1);
  endtask

  // Full write transaction; optionally presents W before AW to check it is held off.
  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input int hold, input bit w_early);
    logic [1:0] exp_r;
    int n;
    exp_r = exp_resp(a);
    if (w_early) begin
      W_VALID = 1'b1;
      W_DATA  = d;
      repeat (2) begin
        @(negedge clk);
        check("wr_w_held_off", W_READY, 0);
      end
    end
    AW_VALID = 1'b1;
    AW_ADDR  = a;
    n = 0;
    while (!AW_READY && n < 50) begin @(negedge clk); n++; end
    check("wr_aw_ready", AW_READY, 1);
    @(negedge clk);
    AW_VALID = 1'b0;
    AW_ADDR  = $urandom;
    check("wr_aw_drop", AW_READY, 0);
    check("wr_w_ready", W_READY, 1);
    W_VALID = 1'b1;
    W_DATA  = d;
    @(negedge clk);
    W_VALID = 1'b0;
    W_DATA  = {$urandom, $urandom};
    if (a < DEPTH) ref_mem[int'(a)] = d;
    check("wr_w_drop", W_READY, 0);
    n = 0;
    while (!B_VALID && n < 300) begin @(negedge clk); n++; end
    check("wr_latency", n, WR_LAT);
    for (int i = 0; i < hold; i++) begin
      check("wr_hold_valid", B_VALID, 1);
      check("wr_hold_resp", B_RESP, exp_r);
      @(negedge clk);
    end
    check("wr_resp", B_RESP, exp_r);
    B_READY = 1'b1;
    @(negedge clk);
    B_READY = 1'b0;
    check("wr_valid_clear", B_VALID, 0);
    check("wr_aw_back", AW_READY, 1);
  endtask

  function automatic logic [31:0] rnd_addr(input int lo, input int hi);
    if ($urandom_range(0, 7) == 0) return 32'(DEPTH + $urandom_range(0, 3000));
    return 32'($urandom_range(lo, hi));
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin : main
    int op;
    logic [31:0] ra, wa;
    AR_VALID = 0; AR_ADDR = 0; R_READY = 0;
    AW_VALID = 0; AW_ADDR = 0; W_VALID = 0; W_DATA = 0; B_READY = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Preload words 0..15 with known non-zero data
    for (int i = 0; i < 16; i++) do_write(32'(i), {$urandom, $urandom} | 64'h1, 0, 0);

    // Basic read latency and data
    do_write(5, 64'h0123_4567_89AB_CDEF, 0, 0);
    do_read(5, 0);

    // Write then read back
    do_write(10, 64'hDEAD_BEEF_0000_0001, 0, 0);
    do_read(10, 0);

    // Out-of-range accesses and aliasing check on word 0
    do_read(8192, 0);
    do_write(9000, 64'hFFFF_0000_FFFF_0000, 0, 0);
    do_write(8192, 64'h1234_5678_1234_5678, 0, 1);
    do_read(0, 0);
    do_read(32'hFFFF_FFFF, 0);

    // Stalled responses stay stable
    do_read(10, 7);
    do_write(11, 64'h5555_AAAA_5555_AAAA, 5, 0);
    do_read(11, 0);

    // Same-edge write commit and read sample on word 3: read sees old data
    do_write(3, 64'h0, 0, 0);
    AR_VALID = 1; AR_ADDR = 3;
    @(negedge clk); AR_VALID = 0;
    repeat (2) @(negedge clk);
    AW_VALID = 1; AW_ADDR = 3; W_VALID = 1; W_DATA = 64'h1;
    @(negedge clk); AW_VALID = 0;
    check("same_edge_w_ready", W_READY, 1);
    @(negedge clk); W_VALID = 0;
    check("same_edge_r_valid", R_VALID, 1);
    check("same_edge_old_data", R_DATA, 64'h0);
    ref_mem[3] = 64'h1;
    R_READY = 1; B_READY = 1;
    repeat (4) @(negedge clk);
    R_READY = 0; B_READY = 0;
    check("same_edge_r_done", R_VALID, 0);
    check("same_edge_b_done", B_VALID, 0);
    check("same_edge_ar_idle", AR_READY, 1);
    check("same_edge_aw_idle", AW_READY, 1);
    do_read(3, 0);

    // Reset while read is in its data phase and write is waiting for its response
    do_write(7, 64'hA5A5_5A5A_C3C3_3C3C, 0, 0);
    do_write(9, 64'h9999_0000_9999_0000, 0, 0);
    AR_VALID = 1; AR_ADDR = 7;
    @(negedge clk); AR_VALID = 0;
    repeat (RD_LAT) @(negedge clk);
    check("rst_pre_r_valid", R_VALID, 1);
    check("rst_pre_r_data", R_DATA, 64'hA5A5_5A5A_C3C3_3C3C);
    AW_VALID = 1; AW_ADDR = 8;
    @(negedge clk); AW_VALID = 0; W_VALID = 1; W_DATA = 64'h8888_1111_8888_1111;
    @(negedge clk); W_VALID = 0;
    ref_mem[8] = 64'h8888_1111_8888_1111;
    #2 rst_n = 0;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    // Reset before the W handshake: nothing committed
    AW_VALID = 1; AW_ADDR = 9;
    @(negedge clk); AW_VALID = 0;
    check("rst_wdata_w_ready", W_READY, 1);
    #2 rst_n = 0;
    #1 check("rst_wdata_w_ready_clr", W_READY, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    do_read(8, 0);
    do_read(9, 0);
    do_read(7, 0);

    // Randomised mix: single reads, single writes, concurrent disjoint read+write
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        do_read(rnd_addr(0, 15), $urandom_range(0, 3));
      end else if (op == 1) begin
        do_write(rnd_addr(0, 15), {$urandom, $urandom}, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end else begin
        ra = rnd_addr(0, 7);
        wa = rnd_addr(8, 15);
        fork
          do_read(ra, $urandom_range(0, 3));
          do_write(wa, {$urandom, $urandom}, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        join
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
